aes_key_sched_ctrl: RTL

AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

---
 rtl/aes_key_sched_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule sequencer: drives an external key-generator datapath, streams round keys 0..NUM_ROUNDS on valid/ready.
// 4 cycles per round at full rate (EMIT, STEP x2, CAPT); stall holds EMIT. Optional abort_i under AES_KEY_SCHED_ABORT_EN.
module aes_key_sched_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         nrst,
`ifdef AES_KEY_SCHED_ABORT_EN
  input  logic         abort_i,
`endif
  input  logic         start_i,
  input  logic [127:0] key_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         kg_en_o,
  output logic         kg_next_rnd_o,
  output logic [3:0]   kg_rnd_number_o,
  output logic [7:0]   kg_rcon_o,
  output logic [127:0] kg_key_o,
  input  logic [127:0] kg_key_i,
  output logic         rk_valid_o,
  input  logic         rk_ready_i,
  output logic [3:0]   rk_idx_o,
  output logic [127:0] rk_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EMIT = 3'd1,
    S_STEP = 3'd2,
    S_CAPT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [3:0] LP_LAST = 4'(NUM_ROUNDS);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [3:0]   r_idx;
  logic         r_phase;
  logic [127:0] r_key;
  logic [7:0]   r_rcon;
  logic         w_load;
  logic         w_capt;
  logic         w_abort;
  logic [7:0]   w_rcon_nxt;

`ifdef AES_KEY_SCHED_ABORT_EN
  assign w_abort = abort_i && (r_state != S_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  // xtime in GF(2^8): next round constant
  assign w_rcon_nxt = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1B : 8'h00);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_idx   <= 4'd0;
      r_phase <= 1'b0;
      r_key   <= 128'd0;
      r_rcon  <= 8'h01;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_STEP) && !w_abort) begin
        r_phase <= ~r_phase;
      end else begin
        r_phase <= 1'b0;
      end
      if (w_load) begin
        r_key  <= key_i;
        r_idx  <= 4'd0;
        r_rcon <= 8'h01;
      end else if (w_capt) begin
        r_key  <= kg_key_i;
        r_idx  <= r_idx + 4'd1;
        r_rcon <= w_rcon_nxt;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_load        = 1'b0;
    w_capt        = 1'b0;
    busy_o        = 1'b1;
    done_o        = 1'b0;
    kg_en_o       = 1'b0;
    kg_next_rnd_o = 1'b0;
    rk_valid_o    = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          w_load      = 1'b1;
          w_state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        rk_valid_o = 1'b1;
        if (rk_ready_i) begin
          w_state_nxt = (r_idx == LP_LAST) ? S_DONE : S_STEP;
        end
      end
      S_STEP: begin
        kg_en_o       = 1'b1;
        // round 1 seeds the datapath from the cipher key, later rounds chain
        kg_next_rnd_o = (r_idx != 4'd0);
        if (r_phase) begin
          w_state_nxt = S_CAPT;
        end
      end
      S_CAPT: begin
        w_capt      = 1'b1;
        w_state_nxt = S_EMIT;
      end
      S_DONE: begin
        done_o      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_abort) begin
      w_capt      = 1'b0;
      w_state_nxt = S_IDLE;
    end
  end

  assign kg_rnd_number_o = r_idx;
  assign kg_rcon_o       = r_rcon;
  assign kg_key_o        = r_key;
  assign rk_idx_o        = r_idx;
  assign rk_o            = r_key;

endmodule
